// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the 16-bit PC / instruction-fetch block.
package pc_fetch_pkg;

  localparam int unsigned WIDTH = 16;

  localparam logic [WIDTH-1:0] DEFAULT_RESET_ADDR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2
  } fetch_state_e;

endpackage : pc_fetch_pkg

// File: rtl/pc_fetch_16_if.sv
// Instruction-memory req/ack port and downstream valid/ready instruction port.
interface pc_fetch_16_if;

  logic                           imem_req;
  logic [pc_fetch_pkg::WIDTH-1:0] imem_addr;
  logic                           imem_ack;
  logic [pc_fetch_pkg::WIDTH-1:0] imem_rdata;
  logic                           instr_valid;
  logic                           instr_ready;
  logic [pc_fetch_pkg::WIDTH-1:0] instr;
  logic [pc_fetch_pkg::WIDTH-1:0] instr_pc;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );

  // Memory / decode side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );

endinterface : pc_fetch_16_if

// File: rtl/inc_16.sv
// 16-bit incrementer; wraps from 16'hFFFF to 16'h0000 with no carry out.
module inc_16 (
  input  logic [15:0] a,
  output logic [15:0] y
);

  assign y = a + 16'd1;

endmodule : inc_16

// File: rtl/pc_fetch_16.sv
// Program counter and instruction-fetch sequencer: req/ack reads from
// instruction memory, valid/ready presentation downstream, jump redirect.
module pc_fetch_16
  import pc_fetch_pkg::*;
#(
  parameter logic [WIDTH-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  pc_fetch_16_if.master    bus,
  output logic [WIDTH-1:0] pc
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic             jump_pend_q, jump_pend_d;
  logic [WIDTH-1:0] target_q, target_d;

  // pc+1 comes only from the shared incrementer
  inc_16 u_inc (
    .a (pc_q),
    .y (pc_inc)
  );

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    jump_pend_d = jump_pend_q;
    target_d    = target_q;

    unique case (state_q)
      IDLE: begin
        if (load) pc_d = load_addr;
        if (run) begin
          state_d = FETCH;
          req_d   = 1'b1;
        end
      end

      FETCH: begin
        if (bus.imem_ack) begin
          if (load) begin
            // fresh jump beats any older pending target; wrong-path data dropped
            pc_d        = load_addr;
            jump_pend_d = 1'b0;
          end else if (jump_pend_q) begin
            pc_d        = target_q;
            jump_pend_d = 1'b0;
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_inc;
            req_d      = 1'b0;
            state_d    = OUT;
          end
        end else if (load) begin
          // keep the address stable until ack; remember the last target
          jump_pend_d = 1'b1;
          target_d    = load_addr;
        end
      end

      OUT: begin
        // the presented instruction is the jump itself, so it is kept
        if (load) pc_d = load_addr;
        if (bus.instr_ready) begin
          valid_d = 1'b0;
          if (run) begin
            state_d = FETCH;
            req_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_ADDR;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      jump_pend_q <= 1'b0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      jump_pend_q <= jump_pend_d;
      target_q    <= target_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign pc              = pc_q;

endmodule : pc_fetch_16

// File: tb/tb_pc_fetch_16.sv
// Directed bench for pc_fetch_16: fetch latency, back-to-back, stall,
// jump redirect, last-wins jumps, wrap-around and mid-fetch reset.
module tb_pc_fetch_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        load;
  logic [15:0] load_addr;
  logic [15:0] pc;

  int tests  = 0;
  int failed = 0;

  pc_fetch_16_if bus ();

  pc_fetch_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .load      (load),
    .load_addr (load_addr),
    .bus       (bus),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    run             = 1'b0;
    load            = 1'b0;
    load_addr       = 16'h0000;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0000;
    bus.instr_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Bounded wait for imem_req
  task automatic wait_req(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (bus.imem_req === 1'b1) ok = 1'b1;
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    tests++; if (pc !== 16'h0000) begin failed++; $display("FAIL rst_pc: got %h want %h", pc, 16'h0000); end
    tests++; if (bus.imem_req !== 1'b0) begin failed++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    tests++; if (bus.instr_valid !== 1'b0) begin failed++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
    tests++; if (bus.instr !== 16'h0000) begin failed++; $display("FAIL rst_instr: got %h want 0000", bus.instr); end
    run = 1'b1;
    wait_req(10, ok);
    tests++; if (!ok) begin failed++; $display("FAIL t1_req_timeout: got 0 want 1"); end
    cyc();
    tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin failed++; $display("FAIL t1_req_hold: got req=%b addr=%h want req=1 addr=0000", bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1234;
    cyc();
    bus.imem_ack = 1'b0;
    tests++; if (bus.instr_valid !== 1'b1) begin failed++; $display("FAIL t1_valid: got %b want 1", bus.instr_valid); end
    tests++; if (bus.instr !== 16'h1234) begin failed++; $display("FAIL t1_instr: got %h want 1234", bus.instr); end
    tests++; if (bus.instr_pc !== 16'h0000) begin failed++; $display("FAIL t1_instr_pc: got %h want 0000", bus.instr_pc); end
    tests++; if (pc !== 16'h0001) begin failed++; $display("FAIL t1_pc: got %h want 0001", pc); end
    tests++; if (bus.imem_req !== 1'b0) begin failed++; $display("FAIL t1_req_drop: got %b want 0", bus.imem_req); end
    run = 1'b0; bus.instr_ready = 1'b1;
    cyc();
    tests++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin failed++; $display("FAIL t1_drain_idle: got valid=%b req=%b want 0 0", bus.instr_valid, bus.imem_req); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    run = 1'b1; bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_req(10, ok);
      tests++; if (!ok) begin failed++; $display("FAIL b2b_req_timeout[%0d]: got 0 want 1", i); end
      tests++; if (bus.imem_addr !== 16'(i)) begin failed++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, bus.imem_addr, 16'(i)); end
      for (int d = 0; d < i; d++) begin
        cyc();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'(i)) begin failed++; $display("FAIL b2b_addr_stable[%0d]: got req=%b addr=%h want req=1 addr=%h", i, bus.imem_req, bus.imem_addr, 16'(i)); end
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = 16'hA000 + 16'(i);
      cyc();
      bus.imem_ack = 1'b0;
      tests++; if (bus.instr_valid !== 1'b1) begin failed++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.instr_valid); end
      tests++; if (bus.instr_pc !== 16'(i)) begin failed++; $display("FAIL b2b_instr_pc[%0d]: got %h want %h", i, bus.instr_pc, 16'(i)); end
      tests++; if (bus.instr !== 16'hA000 + 16'(i)) begin failed++; $display("FAIL b2b_instr[%0d]: got %h want %h", i, bus.instr, 16'hA000 + 16'(i)); end
    end
    run = 1'b0;
    cyc();
    tests++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin failed++; $display("FAIL b2b_drain: got valid=%b req=%b want 0 0", bus.instr_valid, bus.imem_req); end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    run = 1'b1; bus.instr_ready = 1'b0;
    wait_req(10, ok);
    tests++; if (!ok) begin failed++; $display("FAIL stall_req_timeout: got 0 want 1"); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h5555;
    cyc();
    // stray acks while presenting must be ignored; run=0 must not drop the instruction
    bus.imem_rdata = 16'hFFFF; run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      tests++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h5555 || bus.instr_pc !== 16'h0000) begin failed++; $display("FAIL stall_hold[%0d]: got valid=%b instr=%h pc=%h want 1 5555 0000", i, bus.instr_valid, bus.instr, bus.instr_pc); end
      tests++; if (bus.imem_req !== 1'b0) begin failed++; $display("FAIL stall_no_req[%0d]: got %b want 0", i, bus.imem_req); end
    end
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
    cyc();
    tests++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0 || pc !== 16'h0001) begin failed++; $display("FAIL stall_release: got valid=%b req=%b pc=%h want 0 0 0001", bus.instr_valid, bus.imem_req, pc); end
  endtask

  task automatic test_jump_fetch();
    bit ok;
    do_reset();
    run = 1'b1; bus.instr_ready = 1'b1;
    wait_req(10, ok);
    tests++; if (!ok) begin failed++; $display("FAIL jmp_req_timeout: got 0 want 1"); end
    load = 1'b1; load_addr = 16'h00A0;
    cyc();
    load = 1'b0;
    tests++; if (bus.imem_addr !== 16'h0000 || bus.imem_req !== 1'b1) begin failed++; $display("FAIL jmp_addr_hold: got req=%b addr=%h want 1 0000", bus.imem_req, bus.imem_addr); end
    cyc();
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hDEAD;
    cyc();
    bus.imem_ack = 1'b0;
    tests++; if (bus.instr_valid !== 1'b0) begin failed++; $display("FAIL jmp_drop: got valid=%b want 0", bus.instr_valid); end
    tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h00A0) begin failed++; $display("FAIL jmp_redirect: got req=%b addr=%h want 1 00A0", bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hBEEF;
    cyc();
    bus.imem_ack = 1'b0;
    tests++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'hBEEF || bus.instr_pc !== 16'h00A0 || pc !== 16'h00A1) begin failed++; $display("FAIL jmp_target_fetch: got valid=%b instr=%h ipc=%h pc=%h want 1 BEEF 00A0 00A1", bus.instr_valid, bus.instr, bus.instr_pc, pc); end
    run = 1'b0;
    cyc();
  endtask

  task automatic test_last_wins();
    bit ok;
    do_reset();
    run = 1'b1; bus.instr_ready = 1'b1;
    wait_req(10, ok);
    tests++; if (!ok) begin failed++; $display("FAIL lw_req_timeout: got 0 want 1"); end
    load = 1'b1; load_addr = 16'h0010;
    cyc();
    load_addr = 16'h0020;
    cyc();
    load = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 16'h0BAD;
    cyc();
    bus.imem_ack = 1'b0;
    tests++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 16'h0020) begin failed++; $display("FAIL lw_two_loads: got valid=%b addr=%h want 0 0020", bus.instr_valid, bus.imem_addr); end
    // pending 0030, then a load arriving with the ack must win
    load = 1'b1; load_addr = 16'h0030;
    cyc();
    load_addr = 16'h0040; bus.imem_ack = 1'b1;
    cyc();
    load = 1'b0; bus.imem_ack = 1'b0;
    tests++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 16'h0040 || bus.imem_req !== 1'b1) begin failed++; $display("FAIL lw_load_with_ack: got valid=%b req=%b addr=%h want 0 1 0040", bus.instr_valid, bus.imem_req, bus.imem_addr); end
    run = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 16'h4444;
    cyc();
    bus.imem_ack = 1'b0;
    tests++; if (bus.instr !== 16'h4444 || bus.instr_pc !== 16'h0040) begin failed++; $display("FAIL lw_fetch_after: got instr=%h ipc=%h want 4444 0040", bus.instr, bus.instr_pc); end
    cyc();
  endtask

  task automatic test_wrap_and_reset();
    bit ok;
    do_reset();
    run = 1'b1; bus.instr_ready = 1'b0;
    wait_req(10, ok);
    tests++; if (!ok) begin failed++; $display("FAIL wrap_req_timeout: got 0 want 1"); end
    load = 1'b1; load_addr = 16'hFFFF; bus.imem_ack = 1'b1;
    cyc();
    load = 1'b0; bus.imem_ack = 1'b0;
    tests++; if (bus.imem_addr !== 16'hFFFF) begin failed++; $display("FAIL wrap_jump: got %h want FFFF", bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h7777;
    cyc();
    bus.imem_ack = 1'b0;
    tests++; if (pc !== 16'h0000 || bus.instr_pc !== 16'hFFFF || bus.instr !== 16'h7777) begin failed++; $display("FAIL wrap_pc: got pc=%h ipc=%h instr=%h want 0000 FFFF 7777", pc, bus.instr_pc, bus.instr); end
    bus.instr_ready = 1'b1;
    cyc();
    tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin failed++; $display("FAIL wrap_next_fetch: got req=%b addr=%h want 1 0000", bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1111;
    cyc();
    bus.imem_ack = 1'b0;
    cyc();
    tests++; if (bus.imem_req !== 1'b1 || pc !== 16'h0001) begin failed++; $display("FAIL mid_fetch_setup: got req=%b pc=%h want 1 0001", bus.imem_req, pc); end
    // asynchronous reset in the middle of a fetch, with an ack in flight
    #2;
    rst_n = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 16'h9999;
    #1;
    tests++; if (pc !== 16'h0000 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000 || bus.instr_pc !== 16'h0000) begin failed++; $display("FAIL async_reset: got pc=%h req=%b valid=%b instr=%h ipc=%h want all 0", pc, bus.imem_req, bus.instr_valid, bus.instr, bus.instr_pc); end
    cyc();
    tests++; if (bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000) begin failed++; $display("FAIL reset_ack_ignored: got valid=%b instr=%h want 0 0000", bus.instr_valid, bus.instr); end
    bus.imem_ack = 1'b0; run = 1'b0; rst_n = 1'b1;
    cyc();
    tests++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || pc !== 16'h0000) begin failed++; $display("FAIL post_reset_idle: got req=%b valid=%b pc=%h want 0 0 0000", bus.imem_req, bus.instr_valid, pc); end
  endtask

  initial begin
    rst_n           = 1'b0;
    run             = 1'b0;
    load            = 1'b0;
    load_addr       = 16'h0000;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0000;
    bus.instr_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_jump_fetch();
    test_last_wins();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_pc_fetch_16
